branch_resolve_bht: RTL and testbench
=====================================

# branch_resolve_bht

Branch resolution and direction prediction stage for the RV32I core. It drives the branch comparator's signedness select and consumes its `equal`/`lessthan` results in EX to decide the actual branch outcome. It trains a PC-indexed table of 2-bit saturating counters and supplies the taken/not-taken prediction to IF. On a misprediction it raises a registered one-cycle redirect carrying the corrected PC.

## Interface
- `W`, 32, datapath/PC width
- `IDX`, 6, BHT index bits (2^IDX entries)

- `clk` in 1: clock, rising edge
- `rst` in 1: reset, asynchronous, active-high
- `if_pc` in W: fetch PC
- `if_pred_taken` out 1: prediction for `if_pc`, combinational
- `ex_valid` in 1: EX holds a valid instruction
- `ex_is_branch` in 1: EX instruction is a conditional branch
- `ex_stall` in 1: EX frozen this cycle
- `ex_pc` in W: PC of the EX instruction
- `ex_funct3` in 3: branch funct3
- `ex_pred_taken` in 1: prediction made in IF, carried down the pipe
- `ex_target` in W: computed branch target
- `br_unsigned` out 1: comparator signedness select
- `equal` in 1: comparator equal result
- `lessthan` in 1: comparator less-than result
- `redirect` out 1: one-cycle mispredict pulse, registered
- `redirect_pc` out W: corrected fetch PC, valid while `redirect`=1
- `branch_count` out 32: resolved branches
- `mispredict_count` out 32: mispredicted branches

## Operation
- `br_unsigned` = `ex_funct3[1]`, combinational and unconditional.
- Resolve = `ex_valid & ex_is_branch & ~ex_stall & legal`. `legal` is false for funct3 010 and 011.
- Actual taken by funct3:
  - 000 `equal`
  - 001 `~equal`
  - 100 and 110 `lessthan`
  - 101 and 111 `~lessthan`
- Illegal funct3: no resolve, no counter update, no redirect, counts unchanged.
- BHT: 2^IDX entries of 2-bit counters, index = `pc[IDX+1:2]`.
  - Prediction = counter bit 1.
  - Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- On resolve, at the clock edge, the counter at `ex_pc`'s index updates:
  - actual taken: saturating increment, 11 stays 11
  - actual not taken: saturating decrement, 00 stays 00
- Mispredict = resolve & (actual != `ex_pred_taken`). On the next edge:
  - `redirect` is set to 1.
  - `redirect_pc` is set to `ex_target` if actual taken, else `ex_pc + 4` (mod 2^W).
  - Otherwise `redirect` is set to 0 and `redirect_pc` holds its value.
- Counters, on resolve:
  - `branch_count` increments.
  - `mispredict_count` increments only on a mispredict.
  - Both wrap at 2^32.
- The BHT is trained from `ex_pred_taken`-independent actual outcomes. Prediction correctness does not affect training.

## Timing
- Reset, asynchronous and immediate:
  - every BHT entry = 01
  - `redirect` = 0, `redirect_pc` = 0
  - `branch_count` = 0, `mispredict_count` = 0
  - `if_pred_taken` therefore reads 0 after reset.
- Reset asserted mid-operation drops any pending redirect. A redirect due on the next edge does not appear.
- `if_pred_taken` and `br_unsigned` are purely combinational, with zero latency.
- Resolve to `redirect`: 1 cycle. The pulse is exactly 1 cycle wide unless the next EX cycle also mispredicts.
- Back-to-back mispredicts in consecutive cycles: `redirect` stays 1 for both cycles, and `redirect_pc` takes each new value in turn.
- Same-cycle IF read and EX update to the same index: IF sees the pre-update value (read-before-write). The new value is visible from the next cycle.
- `ex_stall`=1 blocks the BHT update, the counters and the redirect, even if `ex_valid` and `ex_is_branch` are 1. The redirect register clears to 0 that cycle.
- The pipeline must flush IF/ID in the cycle `redirect`=1. This block performs no flush itself.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle.
  - All outputs go 0 immediately.
  - `if_pred_taken` = 0 for `if_pc` = 0x0000_0040.
- **Training:** BEQ at `ex_pc` 0x100, `equal`=1, `ex_pred_taken`=0, `ex_target` 0x180.
  - Next cycle: `redirect`=1, `redirect_pc`=0x180.
  - Entry goes 01→10; `if_pred_taken`=1 for `if_pc`=0x100.
  - `branch_count`=1, `mispredict_count`=1.
- **Saturation:** three taken resolves at 0x100, then one not-taken BLT (`lessthan`=0, `ex_pred_taken`=1).
  - Entry sequence 01→10→11→11→10.
  - Final `redirect_pc`=0x104.
- **Signedness and illegal:**
  - funct3=110: `br_unsigned`=1.
  - funct3=100: `br_unsigned`=0.
  - funct3=011 with `ex_valid`=1: no redirect, counts unchanged.
- **Stall and collision:**
  - Mispredicting branch with `ex_stall`=1: no redirect, no counter change.
  - Same-cycle read and update of index 0x100: IF sees the old value, the following cycle sees the new value.
- **Wrap:**
  - `ex_pc`=0xFFFF_FFFC not taken, predicted taken: `redirect_pc`=0x0000_0000.
  - Preload `branch_count` to 0xFFFF_FFFF via force; next resolve gives 0.

Source files
------------

// File: rtl/branch_resolve_bht.sv
// branch_resolve_bht: EX-stage branch resolution plus a PC-indexed table of
// 2-bit saturating direction counters feeding the IF-stage prediction.
//
// Ports
//   clk_i, rst_i          clock (rising edge), async active-high reset
//   if_pc_i               fetch PC; if_pred_taken_o is its prediction (comb)
//   ex_valid_i, ex_is_branch_i, ex_stall_i
//                         EX qualifiers; a branch resolves only when all are
//                         favourable and funct3 is a real branch encoding
//   ex_pc_i, ex_funct3_i, ex_pred_taken_i, ex_target_i
//                         EX branch: PC, condition, IF-time guess, taken target
//   br_unsigned_o         comparator signedness select (comb, = funct3[1])
//   equal_i, lessthan_i   comparator results
//   redirect_o            registered one-cycle mispredict pulse
//   redirect_pc_o         corrected fetch PC, valid while redirect_o=1
//   branch_count_o        resolved branches (wraps)
//   mispredict_count_o    mispredicted branches (wraps)

// One BHT entry: 2-bit saturating counter, resets to weak-not-taken.
module bht_ctr (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       upd_i,
   input  logic       taken_i,
   output logic [1:0] ctr_o
);
   logic [1:0] ctr_q, ctr_d;

   always_comb begin
      ctr_d = ctr_q;
      if (upd_i) begin
         if (taken_i && ctr_q != 2'b11)       ctr_d = ctr_q + 2'd1;
         else if (!taken_i && ctr_q != 2'b00) ctr_d = ctr_q - 2'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) ctr_q <= 2'b01;
      else       ctr_q <= ctr_d;
   end

   assign ctr_o = ctr_q;
endmodule

module branch_resolve_bht #(
   parameter int W   = 32,
   parameter int IDX = 6
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [W-1:0] if_pc_i,
   output logic         if_pred_taken_o,
   input  logic         ex_valid_i,
   input  logic         ex_is_branch_i,
   input  logic         ex_stall_i,
   input  logic [W-1:0] ex_pc_i,
   input  logic [2:0]   ex_funct3_i,
   input  logic         ex_pred_taken_i,
   input  logic [W-1:0] ex_target_i,
   output logic         br_unsigned_o,
   input  logic         equal_i,
   input  logic         lessthan_i,
   output logic         redirect_o,
   output logic [W-1:0] redirect_pc_o,
   output logic [31:0]  branch_count_o,
   output logic [31:0]  mispredict_count_o
);
   localparam int NE = 1 << IDX;

   logic [NE-1:0][1:0] ctr;
   logic [NE-1:0]      upd;
   logic [IDX-1:0]     if_idx, ex_idx;
   logic               legal, resolve, taken, mispredict;

   logic               redirect_q, redirect_d;
   logic [W-1:0]       redirect_pc_q, redirect_pc_d;
   logic [31:0]        branch_cnt_q, branch_cnt_d;
   logic [31:0]        mispred_cnt_q, mispred_cnt_d;

   assign if_idx = if_pc_i[IDX+1:2];
   assign ex_idx = ex_pc_i[IDX+1:2];

   assign br_unsigned_o = ex_funct3_i[1];

   // funct3 01x is not a branch encoding
   assign legal   = (ex_funct3_i[2:1] != 2'b01);
   assign resolve = ex_valid_i & ex_is_branch_i & ~ex_stall_i & legal;
   // funct3[2] picks lt vs eq, funct3[0] inverts the sense
   assign taken      = (ex_funct3_i[2] ? lessthan_i : equal_i) ^ ex_funct3_i[0];
   assign mispredict = resolve & (taken != ex_pred_taken_i);

   genvar e;
   generate
      for (e = 0; e < NE; e++) begin : g_bht
         assign upd[e] = resolve & (ex_idx == IDX'(e));
         bht_ctr u_ctr (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .upd_i   (upd[e]),
            .taken_i (taken),
            .ctr_o   (ctr[e])
         );
      end
   endgenerate

   // Reads the registered counter, so a same-cycle update is seen next cycle
   assign if_pred_taken_o = ctr[if_idx][1];

   always_comb begin
      redirect_d    = mispredict;
      redirect_pc_d = redirect_pc_q;
      if (mispredict) redirect_pc_d = taken ? ex_target_i : ex_pc_i + W'(4);
      branch_cnt_d  = branch_cnt_q + 32'(resolve);
      mispred_cnt_d = mispred_cnt_q + 32'(mispredict);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
         branch_cnt_q  <= branch_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign redirect_o         = redirect_q;
   assign redirect_pc_o      = redirect_pc_q;
   assign branch_count_o     = branch_cnt_q;
   assign mispredict_count_o = mispred_cnt_q;
endmodule

// File: tb/tb_branch_resolve_bht.sv
module tb_branch_resolve_bht;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] if_pc = '0;
   logic        if_pred_taken;
   logic        ex_valid = 1'b0, ex_is_branch = 1'b0, ex_stall = 1'b0;
   logic [31:0] ex_pc = '0;
   logic [2:0]  ex_funct3 = '0;
   logic        ex_pred_taken = 1'b0;
   logic [31:0] ex_target = '0;
   logic        br_unsigned;
   logic        equal = 1'b0, lessthan = 1'b0;
   logic        redirect;
   logic [31:0] redirect_pc, branch_count, mispredict_count;

   int total = 0;
   int bad   = 0;
   logic pl = 1'b0;   // branch_count preload in progress

   // behavioural model
   int          m_bht [64];
   logic        m_red;
   logic [31:0] m_rpc, m_bc, m_mc;

   always #5 clk = ~clk;

   branch_resolve_bht #(.W(32), .IDX(6)) dut (
      .clk_i(clk), .rst_i(rst), .if_pc_i(if_pc), .if_pred_taken_o(if_pred_taken),
      .ex_valid_i(ex_valid), .ex_is_branch_i(ex_is_branch), .ex_stall_i(ex_stall),
      .ex_pc_i(ex_pc), .ex_funct3_i(ex_funct3), .ex_pred_taken_i(ex_pred_taken),
      .ex_target_i(ex_target), .br_unsigned_o(br_unsigned), .equal_i(equal),
      .lessthan_i(lessthan), .redirect_o(redirect), .redirect_pc_o(redirect_pc),
      .branch_count_o(branch_count), .mispredict_count_o(mispredict_count)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: outcome from the funct3 table, counters as clamped integers
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 64; i++) m_bht[i] = 1;
         m_red = 1'b0; m_rpc = '0; m_bc = '0; m_mc = '0;
      end else begin
         bit tk, res, mis;
         int ix;
         case (ex_funct3)
            3'd0:       tk = equal;
            3'd1:       tk = !equal;
            3'd4, 3'd6: tk = lessthan;
            3'd5, 3'd7: tk = !lessthan;
            default:    tk = 1'b0;
         endcase
         res = ex_valid && ex_is_branch && !ex_stall && !(ex_funct3 inside {3'd2, 3'd3});
         mis = res && (tk != ex_pred_taken);
         ix  = int'((ex_pc / 4) % 64);
         if (pl) m_bc = 32'hFFFF_FFFF;
         if (res) begin
            m_bht[ix] = tk ? ((m_bht[ix] < 3) ? m_bht[ix] + 1 : 3)
                           : ((m_bht[ix] > 0) ? m_bht[ix] - 1 : 0);
            m_bc = m_bc + 1;
            if (mis) m_mc = m_mc + 1;
         end
         m_red = mis;
         if (mis) m_rpc = tk ? ex_target : ex_pc + 32'd4;
      end
   end

   // Compare process
   always @(negedge clk) begin
      if (!rst) begin
         chk("pred", {31'd0, if_pred_taken}, {31'd0, m_bht[int'((if_pc / 4) % 64)] >= 2});
         chk("br_unsigned", {31'd0, br_unsigned}, {31'd0, ex_funct3 inside {3'd2, 3'd3, 3'd6, 3'd7}});
         chk("redirect", {31'd0, redirect}, {31'd0, m_red});
         chk("redirect_pc", redirect_pc, m_rpc);
         if (!pl) chk("branch_count", branch_count, m_bc);
         chk("mispredict_count", mispredict_count, m_mc);
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic br(input logic v, input logic b, input logic s, input logic [31:0] pc,
                     input logic [2:0] f3, input logic pr, input logic [31:0] tg,
                     input logic eq, input logic lt, input logic [31:0] ipc);
      ex_valid = v; ex_is_branch = b; ex_stall = s; ex_pc = pc; ex_funct3 = f3;
      ex_pred_taken = pr; ex_target = tg; equal = eq; lessthan = lt; if_pc = ipc;
   endtask

   task automatic idle();
      br(1'b0, 1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h40);
   endtask

   initial begin
      idle();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_redirect", {31'd0, redirect}, 32'd0);
      chk("rst_rpc", redirect_pc, 32'd0);
      chk("rst_bc", branch_count, 32'd0);
      chk("rst_mc", mispredict_count, 32'd0);
      chk("rst_pred40", {31'd0, if_pred_taken}, 32'd0);

      // training: BEQ taken, predicted NT
      br(1, 1, 0, 32'h100, 3'd0, 0, 32'h180, 1, 0, 32'h100);
      #1 chk("train_pred_old", {31'd0, if_pred_taken}, 32'd0);
      tick();
      chk("train_redirect", {31'd0, redirect}, 32'd1);
      chk("train_rpc", redirect_pc, 32'h180);
      chk("train_pred_new", {31'd0, if_pred_taken}, 32'd1);
      chk("train_bc", branch_count, 32'd1);
      chk("train_mc", mispredict_count, 32'd1);
      chk("model_bht_10", m_bht[0], 32'd2);

      // saturation: two more taken, then not-taken BLT predicted T
      br(1, 1, 0, 32'h100, 3'd0, 1, 32'h180, 1, 0, 32'h100);
      tick();
      chk("sat_noredir", {31'd0, redirect}, 32'd0);
      chk("model_bht_11", m_bht[0], 32'd3);
      tick();
      chk("model_bht_11b", m_bht[0], 32'd3);
      br(1, 1, 0, 32'h100, 3'd4, 1, 32'h180, 0, 0, 32'h100);
      tick();
      chk("sat_redirect", {31'd0, redirect}, 32'd1);
      chk("sat_rpc", redirect_pc, 32'h104);
      chk("sat_pred", {31'd0, if_pred_taken}, 32'd1);
      chk("model_bht_10b", m_bht[0], 32'd2);
      chk("sat_bc", branch_count, 32'd4);
      chk("sat_mc", mispredict_count, 32'd2);

      // signedness and illegal
      br(0, 1, 0, 32'h100, 3'd6, 0, 32'h0, 0, 0, 32'h100);
      #1 chk("uns_110", {31'd0, br_unsigned}, 32'd1);
      ex_funct3 = 3'd4;
      #1 chk("uns_100", {31'd0, br_unsigned}, 32'd0);
      br(1, 1, 0, 32'h100, 3'd3, 0, 32'h300, 1, 1, 32'h100);
      tick();
      chk("ill_redirect", {31'd0, redirect}, 32'd0);
      chk("ill_bc", branch_count, 32'd4);
      chk("ill_mc", mispredict_count, 32'd2);

      // stall blocks a mispredicting branch
      br(1, 1, 1, 32'h100, 3'd0, 0, 32'h300, 1, 0, 32'h100);
      tick();
      chk("stall_redirect", {31'd0, redirect}, 32'd0);
      chk("stall_bc", branch_count, 32'd4);
      chk("stall_pred", {31'd0, if_pred_taken}, 32'd1);

      // collision: BNE not taken at 0x100 while IF reads 0x100 (10 -> 01)
      br(1, 1, 0, 32'h100, 3'd1, 0, 32'h300, 1, 0, 32'h100);
      #1 chk("coll_old", {31'd0, if_pred_taken}, 32'd1);
      tick();
      chk("coll_new", {31'd0, if_pred_taken}, 32'd0);
      chk("coll_redirect", {31'd0, redirect}, 32'd0);
      chk("coll_bc", branch_count, 32'd5);

      // PC wrap
      br(1, 1, 0, 32'hFFFF_FFFC, 3'd0, 1, 32'h500, 0, 0, 32'h40);
      tick();
      chk("wrap_redirect", {31'd0, redirect}, 32'd1);
      chk("wrap_rpc", redirect_pc, 32'h0);
      chk("wrap_mc", mispredict_count, 32'd3);

      // branch_count wrap via preload
      force dut.branch_cnt_q = 32'hFFFF_FFFF;
      #1 release dut.branch_cnt_q;
      pl = 1'b1;
      br(1, 1, 0, 32'h200, 3'd5, 0, 32'h280, 0, 0, 32'h40);
      tick();
      pl = 1'b0;
      chk("cnt_wrap", branch_count, 32'd0);

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         logic [31:0] pc, ipc;
         pc  = ($urandom_range(0, 9) == 0) ? ($urandom & 32'hFFFF_FFFC)
                                           : 32'h100 + 32'($urandom_range(0, 7)) * 4;
         ipc = ($urandom_range(0, 1) == 0) ? pc : 32'h100 + 32'($urandom_range(0, 7)) * 4;
         br($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
            pc, 3'($urandom), 1'($urandom), $urandom, 1'($urandom), 1'($urandom), ipc);
         tick();
      end

      // async reset mid-cycle drops a pending redirect
      br(1, 1, 0, 32'h200, 3'd0, 0, 32'h280, 1, 0, 32'h40);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_redirect", {31'd0, redirect}, 32'd0);
      chk("arst_rpc", redirect_pc, 32'd0);
      chk("arst_bc", branch_count, 32'd0);
      chk("arst_mc", mispredict_count, 32'd0);
      chk("arst_pred40", {31'd0, if_pred_taken}, 32'd0);
      tick();
      chk("arst_nopulse", {31'd0, redirect}, 32'd0);
      idle();
      rst = 1'b0;
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
